// File: rtl/tdm_sched_pkg.sv
// Shared types for the TDM slot scheduler: slot-table entry, FSM state and
// the power-on ownership table.
package tdm_sched_pkg;

  // Wide enough for the largest supported requester count (8).
  localparam int OWNER_W = 3;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
  } slot_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Power-on table: slot s belongs to requester s mod num_req.
  function automatic slot_entry_t default_entry(input int slot, input int num_req);
    slot_entry_t e;
    e.valid = 1'b1;
    e.owner = OWNER_W'(slot % num_req);
    return e;
  endfunction

endpackage

// File: rtl/tdm_slot_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo N. Reusable by any arbiter that keeps its own pointer.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         found,
  output logic [W-1:0] winner
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] idx;

  // Walk ptr+1 .. ptr+N; the first hit wins, so later hits are ignored.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = rr_ptr;
    for (int i = 0; i < N; i++) begin
      idx = (idx == LAST) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tdm_slot_scheduler.sv
// Time-division scheduler: a slot counter walks a programmable ownership table
// and grants one requester per slot, backfilling idle slots round-robin.
module tdm_slot_scheduler
  import tdm_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_SLOTS = 6,
  parameter  int SLOT_LEN  = 4,
  localparam int SW        = $clog2(NUM_SLOTS),
  localparam int RW        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               cfg_we,
  input  logic [SW-1:0]      cfg_slot,
  input  logic [RW-1:0]      cfg_owner,
  input  logic               cfg_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [SW-1:0]      slot_idx,
  output logic               slot_start,
  output logic               frame_start
);

  localparam int            CW        = $clog2(SLOT_LEN);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(SLOT_LEN - 1);
  localparam logic [RW-1:0] LAST_REQ  = RW'(NUM_REQ - 1);

  state_t             state;
  logic [CW-1:0]      cycle_cnt;
  logic [RW-1:0]      rr_ptr;
  slot_entry_t        slot_table [NUM_SLOTS];

  logic               at_boundary;
  logic [SW-1:0]      next_slot;
  logic [SW-1:0]      arb_slot;
  slot_entry_t        arb_entry;
  logic [NUM_REQ-1:0] owner_mask;
  logic               owner_hit;
  logic               bf_found;
  logic [RW-1:0]      bf_winner;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_take_bf;

  assign at_boundary = (cycle_cnt == LAST_CYC);
  assign next_slot   = (slot_idx == LAST_SLOT) ? '0 : slot_idx + 1'b1;
  // IDLE re-arbitrates the slot it stopped in; RUN arbitrates the slot about to start.
  assign arb_slot    = (state == IDLE) ? slot_idx : next_slot;
  assign arb_entry   = slot_table[arb_slot];

  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_entry.owner == OWNER_W'(i)) begin
        owner_mask[i] = 1'b1;
      end
    end
  end

  assign owner_hit = arb_entry.valid && ((owner_mask & req) != '0);

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (bf_found),
    .winner (bf_winner)
  );

  // The owner always wins its own slot; only backfill moves the RR pointer.
  always_comb begin
    arb_grant   = '0;
    arb_take_bf = 1'b0;
    if (owner_hit) begin
      arb_grant = owner_mask;
    end else if (bf_found) begin
      arb_grant[bf_winner] = 1'b1;
      arb_take_bf          = 1'b1;
    end
  end

  // The table is read combinationally, so a same-cycle write lands after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_table[s] <= default_entry(s, NUM_REQ);
      end
    end else if (cfg_we && (cfg_slot <= LAST_SLOT)) begin
      slot_table[cfg_slot] <= '{valid: cfg_valid, owner: OWNER_W'(cfg_owner)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot_idx    <= '0;
      cycle_cnt   <= '0;
      grant       <= '0;
      slot_start  <= 1'b0;
      frame_start <= 1'b0;
      rr_ptr      <= LAST_REQ;
    end else begin
      slot_start  <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state       <= RUN;
            grant       <= arb_grant;
            slot_start  <= 1'b1;
            frame_start <= (slot_idx == '0);
            cycle_cnt   <= '0;
            if (arb_take_bf) begin
              rr_ptr <= bf_winner;
            end
          end else begin
            grant <= '0;
          end
        end
        RUN: begin
          if (!en) begin
            state     <= IDLE;
            grant     <= '0;
            cycle_cnt <= '0;
          end else if (at_boundary) begin
            slot_idx    <= next_slot;
            cycle_cnt   <= '0;
            grant       <= arb_grant;
            slot_start  <= 1'b1;
            frame_start <= (next_slot == '0);
            if (arb_take_bf) begin
              rr_ptr <= bf_winner;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            // A released slot stays empty until the next boundary.
            if ((grant & req) == '0) begin
              grant <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Directed vector bench for tdm_slot_scheduler (4 requesters, 6 slots, 4 cycles/slot).
module tb_tdm_slot_scheduler;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       cfg_we;
    logic [2:0] cfg_slot;
    logic [1:0] cfg_owner;
    logic       cfg_valid;
    logic [3:0] exp_grant;
    logic [2:0] exp_slot;
    logic       exp_ss;
    logic       exp_fs;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = '0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_slot = '0;
  logic [1:0] cfg_owner = '0;
  logic       cfg_valid = 1'b0;
  logic [3:0] grant;
  logic [2:0] slot_idx;
  logic       slot_start;
  logic       frame_start;

  int   vectors_applied = 0;
  int   miscompares = 0;
  vec_t vecs[$];

  tdm_slot_scheduler #(
    .NUM_REQ   (4),
    .NUM_SLOTS (6),
    .SLOT_LEN  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .cfg_we      (cfg_we),
    .cfg_slot    (cfg_slot),
    .cfg_owner   (cfg_owner),
    .cfg_valid   (cfg_valid),
    .grant       (grant),
    .slot_idx    (slot_idx),
    .slot_start  (slot_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en_i, input logic [3:0] req_i, input logic [3:0] g,
                              input logic [2:0] s, input logic ss, input logic fs);
    vec_t v;
    v.en        = en_i;
    v.req       = req_i;
    v.cfg_we    = 1'b0;
    v.cfg_slot  = '0;
    v.cfg_owner = '0;
    v.cfg_valid = 1'b0;
    v.exp_grant = g;
    v.exp_slot  = s;
    v.exp_ss    = ss;
    v.exp_fs    = fs;
    return v;
  endfunction

  task automatic addSlot(input logic [3:0] r, input logic [3:0] g, input int s, input int n = 4);
    for (int c = 0; c < n; c++) begin
      vecs.push_back(mk(1'b1, r, g, 3'(s), (c == 0), (c == 0) && (s == 0)));
    end
  endtask

  task automatic setCfg(input int idx, input int s, input int owner, input logic valid);
    vecs[idx].cfg_we    = 1'b1;
    vecs[idx].cfg_slot  = 3'(s);
    vecs[idx].cfg_owner = 2'(owner);
    vecs[idx].cfg_valid = valid;
  endtask

  task automatic applyStimulus(input vec_t v);
    en        = v.en;
    req       = v.req;
    cfg_we    = v.cfg_we;
    cfg_slot  = v.cfg_slot;
    cfg_owner = v.cfg_owner;
    cfg_valid = v.cfg_valid;
  endtask

  task automatic checkOutput(input vec_t v, input string tag, input int idx);
    vectors_applied++;
    if (grant !== v.exp_grant) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d] grant: got %b, want %b", tag, idx, grant, v.exp_grant);
    end
    if (slot_idx !== v.exp_slot) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d] slot_idx: got %0d, want %0d", tag, idx, slot_idx, v.exp_slot);
    end
    if (slot_start !== v.exp_ss) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d] slot_start: got %b, want %b", tag, idx, slot_start, v.exp_ss);
    end
    if (frame_start !== v.exp_fs) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d] frame_start: got %b, want %b", tag, idx, frame_start, v.exp_fs);
    end
  endtask

  task automatic runVectors(input string tag);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      checkOutput(vecs[i], tag, i);
    end
    vecs.delete();
  endtask

  // Reset is asserted between clock edges and checked before any edge arrives.
  task automatic resetDut(input string tag);
    #2;
    rst_n  = 1'b0;
    en     = 1'b0;
    req    = '0;
    cfg_we = 1'b0;
    #1;
    checkOutput(mk(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0), tag, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] grants_c [7];
    logic [3:0] grants_d [16];
    grants_c = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    grants_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                 4'b0001, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                 4'b0001, 4'b1000, 4'b0001, 4'b0010};

    $display("[TB] start");

    // All requesting: every slot goes to its default owner, frame wraps.
    resetDut("reset_a");
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 3'd0, 1'b0, 1'b0));
    for (int s = 0; s < 7; s++) begin
      addSlot(4'b1111, 4'b0001 << ((s % 6) % 4), s % 6);
    end
    runVectors("all_req");

    // Single requester takes every slot; an empty request set leaves the slot ungranted.
    resetDut("reset_b");
    for (int s = 0; s < 6; s++) begin
      addSlot(4'b0100, 4'b0100, s);
    end
    addSlot(4'b0000, 4'b0000, 0);
    runVectors("single_req");

    // Owners 0/1 keep their slots, slots 2 and 3 backfill round-robin.
    resetDut("reset_c");
    for (int s = 0; s < 7; s++) begin
      addSlot(4'b0011, grants_c[s], s % 6);
    end
    runVectors("backfill");

    // Table writes: same-cycle read sees old entry, out-of-range writes ignored.
    resetDut("reset_d");
    for (int s = 0; s < 16; s++) begin
      addSlot(4'b1111, grants_d[s], s % 6);
    end
    setCfg(8, 2, 0, 1'b1);
    setCfg(13, 1, 3, 1'b1);
    setCfg(14, 7, 2, 1'b0);
    setCfg(15, 6, 1, 1'b0);
    setCfg(20, 3, 3, 1'b0);
    runVectors("config");

    // Mid-slot release, then en dropped and restored in slot 2.
    resetDut("reset_e");
    addSlot(4'b1111, 4'b0001, 0);
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0010, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0010, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1101, 4'b0000, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 3'd1, 1'b0, 1'b0));
    addSlot(4'b1111, 4'b0100, 2, 2);
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 3'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 3'd2, 1'b0, 1'b0));
    addSlot(4'b1111, 4'b0100, 2);
    addSlot(4'b1111, 4'b1000, 3, 2);
    runVectors("release_en");

    // Asynchronous reset in the middle of slot 3 with a live grant.
    resetDut("async_mid_slot");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
